// File: rtl/cva6_wrapper_bus_arbiter.sv
// Purpose: round-robin 2-initiator to 4-target request/grant bus with fixed memory-map decode; one transaction in flight; optional timeout via CVA6_WRAPPER_ARB_TIMEOUT_EN.
// Latency: gnt_o combinational in IDLE (cycle N); tgt_req_o at N+1; rvalid_o two cycles after tgt_gnt_i at the earliest; decode miss answers at N+1.
// Backpressure: initiators hold req_i until gnt_o; the target command is held until tgt_gnt_i, and new requests wait while a transaction is open.
module cva6_wrapper_bus_arbiter #(
    parameter int unsigned NumInit       = 2,
    parameter int unsigned NumTgt        = 4,
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumInit-1:0]                    req_i,
    input  logic [NumInit-1:0]                    we_i,
    input  logic [NumInit-1:0][AddrWidth-1:0]     addr_i,
    input  logic [NumInit-1:0][DataWidth-1:0]     wdata_i,
    input  logic [NumInit-1:0][DataWidth/8-1:0]   be_i,
    output logic [NumInit-1:0]                    gnt_o,
    output logic [NumInit-1:0]                    rvalid_o,
    output logic [DataWidth-1:0]                  rdata_o,
    output logic                                  err_o,
    output logic [NumTgt-1:0]                     tgt_req_o,
    output logic                                  tgt_we_o,
    output logic [AddrWidth-1:0]                  tgt_addr_o,
    output logic [DataWidth-1:0]                  tgt_wdata_o,
    output logic [DataWidth/8-1:0]                tgt_be_o,
    input  logic [NumTgt-1:0]                     tgt_gnt_i,
    input  logic [NumTgt-1:0]                     tgt_rvalid_i,
    input  logic [NumTgt-1:0][DataWidth-1:0]      tgt_rdata_i,
    input  logic [NumTgt-1:0]                     tgt_err_i
);

    localparam int unsigned InitIdxW = (NumInit > 1) ? $clog2(NumInit) : 1;
    localparam int unsigned TgtIdxW  = (NumTgt > 1) ? $clog2(NumTgt) : 1;

    typedef logic [AddrWidth-1:0] addr_t;

    localparam addr_t DbgBase   = addr_t'(64'h0000_0000);
    localparam addr_t DbgEnd    = DbgBase + addr_t'(64'h0000_1000);
    localparam addr_t ClintBase = addr_t'(64'h0200_0000);
    localparam addr_t ClintEnd  = ClintBase + addr_t'(64'h000C_0000);
    localparam addr_t PlicBase  = addr_t'(64'h0C00_0000);
    localparam addr_t PlicEnd   = PlicBase + addr_t'(64'h03FF_FFFF);
    localparam addr_t ExtBase   = addr_t'(64'h1000_0000);
    localparam addr_t ExtEnd    = ExtBase + addr_t'(64'hEFFF_FFFF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } state_e;

    state_e                 stateQ, stateD;
    logic [InitIdxW-1:0]    rrPtrQ;
    logic [InitIdxW-1:0]    ownerQ;
    logic [TgtIdxW-1:0]     selQ;
    logic                   weQ;
    addr_t                  addrQ;
    logic [DataWidth-1:0]   wdataQ;
    logic [DataWidth/8-1:0] beQ;
    logic [DataWidth-1:0]   rdataQ;
    logic                   errQ;

    logic                   anyReq;
    logic                   found;
    logic [InitIdxW-1:0]    winner;
    logic [InitIdxW-1:0]    cand;
    logic [InitIdxW-1:0]    nextPtr;
    addr_t                  winAddr;
    logic                   decHit;
    logic [TgtIdxW-1:0]     decSel;
    logic                   latch;
    logic                   rspLoad;
    logic [DataWidth-1:0]   rspData;
    logic                   rspErr;
    logic                   timeout;

    // Search starts at the pointer so a lone requester wins regardless of it.
    always_comb begin
        anyReq = |req_i;
        found  = 1'b0;
        winner = rrPtrQ;
        cand   = rrPtrQ;
        for (int k = 0; k < int'(NumInit); k++) begin
            cand = InitIdxW'((int'(rrPtrQ) + k) % int'(NumInit));
            if (!found && req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
        nextPtr = (int'(winner) == int'(NumInit) - 1) ? '0 : winner + 1'b1;
        winAddr = addr_i[winner];
    end

    always_comb begin
        decHit = 1'b0;
        decSel = '0;
        if (winAddr >= ExtBase && winAddr < ExtEnd) begin
            decHit = 1'b1;
            decSel = TgtIdxW'(0);
        end
        if (winAddr >= PlicBase && winAddr < PlicEnd) begin
            decHit = 1'b1;
            decSel = TgtIdxW'(1);
        end
        if (winAddr >= ClintBase && winAddr < ClintEnd) begin
            decHit = 1'b1;
            decSel = TgtIdxW'(2);
        end
        if (winAddr >= DbgBase && winAddr < DbgEnd) begin
            decHit = 1'b1;
            decSel = TgtIdxW'(3);
        end
    end

`ifdef CVA6_WRAPPER_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cntQ;

    always_ff @(posedge clk_i) begin
        if (rst_i || stateQ == IDLE) begin
            cntQ <= '0;
        end else if (stateQ == REQ || stateQ == WAIT) begin
            cntQ <= cntQ + 1'b1;
        end
    end

    // Fires in the last permitted REQ/WAIT cycle; a same-cycle gnt or rvalid still wins.
    assign timeout = (cntQ == CntW'(TimeoutCycles - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        stateD    = stateQ;
        gnt_o     = '0;
        rvalid_o  = '0;
        tgt_req_o = '0;
        latch     = 1'b0;
        rspLoad   = 1'b0;
        rspData   = '0;
        rspErr    = 1'b0;
        case (stateQ)
            IDLE: begin
                if (anyReq && !rst_i) begin
                    gnt_o[winner] = 1'b1;
                    latch         = 1'b1;
                    if (decHit) begin
                        stateD = REQ;
                    end else begin
                        stateD  = RSP;
                        rspLoad = 1'b1;
                        rspErr  = 1'b1;
                    end
                end
            end
            REQ: begin
                tgt_req_o[selQ] = 1'b1;
                if (tgt_gnt_i[selQ]) begin
                    stateD = WAIT;
                end else if (timeout) begin
                    stateD  = RSP;
                    rspLoad = 1'b1;
                    rspErr  = 1'b1;
                end
            end
            WAIT: begin
                if (tgt_rvalid_i[selQ]) begin
                    stateD  = RSP;
                    rspLoad = 1'b1;
                    rspData = tgt_rdata_i[selQ];
                    rspErr  = tgt_err_i[selQ];
                end else if (timeout) begin
                    stateD  = RSP;
                    rspLoad = 1'b1;
                    rspErr  = 1'b1;
                end
            end
            RSP: begin
                rvalid_o[ownerQ] = 1'b1;
                stateD           = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rrPtrQ <= '0;
            ownerQ <= '0;
            selQ   <= '0;
            weQ    <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
            beQ    <= '0;
            rdataQ <= '0;
            errQ   <= 1'b0;
        end else begin
            if (latch) begin
                rrPtrQ <= nextPtr;
                ownerQ <= winner;
                selQ   <= decSel;
                weQ    <= we_i[winner];
                addrQ  <= winAddr;
                wdataQ <= wdata_i[winner];
                beQ    <= be_i[winner];
            end
            if (rspLoad) begin
                rdataQ <= rspData;
                errQ   <= rspErr;
            end
        end
    end

    assign tgt_we_o    = weQ;
    assign tgt_addr_o  = addrQ;
    assign tgt_wdata_o = wdataQ;
    assign tgt_be_o    = beQ;
    assign rdata_o     = rdataQ;
    assign err_o       = errQ;

endmodule

// File: tb/tb_cva6_wrapper_bus_arbiter.sv
// Directed bench for cva6_wrapper_bus_arbiter: inputs change at the falling edge, outputs are sampled 1ns later.
// The timeout scenario is compiled only when CVA6_WRAPPER_ARB_TIMEOUT_EN is defined.
module tb_cva6_wrapper_bus_arbiter;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [1:0]        req_i;
    logic [1:0]        we_i;
    logic [1:0][63:0]  addr_i;
    logic [1:0][63:0]  wdata_i;
    logic [1:0][7:0]   be_i;
    logic [1:0]        gnt_o;
    logic [1:0]        rvalid_o;
    logic [63:0]       rdata_o;
    logic              err_o;
    logic [3:0]        tgt_req_o;
    logic              tgt_we_o;
    logic [63:0]       tgt_addr_o;
    logic [63:0]       tgt_wdata_o;
    logic [7:0]        tgt_be_o;
    logic [3:0]        tgt_gnt_i;
    logic [3:0]        tgt_rvalid_i;
    logic [3:0][63:0]  tgt_rdata_i;
    logic [3:0]        tgt_err_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cva6_wrapper_bus_arbiter #(
        .NumInit(2), .NumTgt(4), .AddrWidth(64), .DataWidth(64), .TimeoutCycles(16)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .tgt_req_o(tgt_req_o), .tgt_we_o(tgt_we_o),
        .tgt_addr_o(tgt_addr_o), .tgt_wdata_o(tgt_wdata_o), .tgt_be_o(tgt_be_o),
        .tgt_gnt_i(tgt_gnt_i), .tgt_rvalid_i(tgt_rvalid_i), .tgt_rdata_i(tgt_rdata_i),
        .tgt_err_i(tgt_err_i)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic test_reset();
        rst_i = 1'b1; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
        tgt_gnt_i = '0; tgt_rvalid_i = '0; tgt_rdata_i = '0; tgt_err_i = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
        checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", rvalid_o); end
        checks++; if (tgt_req_o !== 4'b0000) begin errors++; $display("FAIL reset_tgt_req: got %b want 0000", tgt_req_o); end
        checks++; if (rdata_o !== 64'h0 || err_o !== 1'b0) begin errors++; $display("FAIL reset_rsp: got rdata %h err %b want 0 0", rdata_o, err_o); end
        checks++; if (tgt_addr_o !== 64'h0) begin errors++; $display("FAIL reset_tgt_addr: got %h want 0", tgt_addr_o); end
        rst_i = 1'b0;
    endtask

    // Both initiators target unmapped space so each grant is followed by a one-cycle error response.
    task automatic test_round_robin();
        logic [1:0] exp;
        @(negedge clk);
        req_i = 2'b11;
        addr_i[0] = 64'h0100_0000;
        addr_i[1] = 64'h0100_0008;
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++; if (gnt_o !== exp) begin errors++; $display("FAIL rr_gnt%0d: got %b want %b", i, gnt_o, exp); end
            @(negedge clk);
            #1;
            checks++; if (rvalid_o !== exp || gnt_o !== 2'b00 || err_o !== 1'b1) begin
                errors++; $display("FAIL rr_rsp%0d: got rvalid %b gnt %b err %b want rvalid %b gnt 00 err 1", i, rvalid_o, gnt_o, err_o, exp);
            end
            @(negedge clk);
        end
        req_i = 2'b00;
    endtask

    task automatic test_clint_read();
        @(negedge clk);
        req_i = 2'b10; we_i = 2'b00; addr_i[1] = 64'h0200_BFF8; be_i[1] = 8'hFF;
        #1;
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL clint_gnt: got %b want 10", gnt_o); end
        @(negedge clk);
        req_i = 2'b00;
        #1;
        checks++; if (tgt_req_o !== 4'b0100) begin errors++; $display("FAIL clint_tgt_req: got %b want 0100", tgt_req_o); end
        checks++; if (tgt_addr_o !== 64'h0200_BFF8 || tgt_we_o !== 1'b0) begin
            errors++; $display("FAIL clint_cmd: got addr %h we %b want 0200bff8 0", tgt_addr_o, tgt_we_o);
        end
        tgt_gnt_i = 4'b0100;
        @(negedge clk);
        tgt_gnt_i = 4'b0000; tgt_rvalid_i = 4'b0100; tgt_rdata_i[2] = 64'hDEAD_BEEF; tgt_err_i = 4'b0000;
        #1;
        checks++; if (tgt_req_o !== 4'b0000 || rvalid_o !== 2'b00) begin
            errors++; $display("FAIL clint_wait: got tgt_req %b rvalid %b want 0000 00", tgt_req_o, rvalid_o);
        end
        @(negedge clk);
        tgt_rvalid_i = 4'b0000;
        #1;
        checks++; if (rvalid_o !== 2'b10 || rdata_o !== 64'hDEAD_BEEF || err_o !== 1'b0) begin
            errors++; $display("FAIL clint_rsp: got rvalid %b rdata %h err %b want 10 deadbeef 0", rvalid_o, rdata_o, err_o);
        end
        @(negedge clk);
        #1;
        checks++; if (rvalid_o !== 2'b00 || rdata_o !== 64'hDEAD_BEEF) begin
            errors++; $display("FAIL clint_hold: got rvalid %b rdata %h want 00 deadbeef", rvalid_o, rdata_o);
        end
    endtask

    task automatic test_miss();
        @(negedge clk);
        req_i = 2'b10; addr_i[1] = 64'h0100_0000;
        #1;
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL miss_gnt: got %b want 10", gnt_o); end
        @(negedge clk);
        req_i = 2'b00;
        #1;
        checks++; if (tgt_req_o !== 4'b0000) begin errors++; $display("FAIL miss_tgt_req: got %b want 0000", tgt_req_o); end
        checks++; if (rvalid_o !== 2'b10 || err_o !== 1'b1 || rdata_o !== 64'h0) begin
            errors++; $display("FAIL miss_rsp: got rvalid %b err %b rdata %h want 10 1 0", rvalid_o, err_o, rdata_o);
        end
        @(negedge clk);
        #1;
        checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL miss_done: got %b want 00", rvalid_o); end
    endtask

    task automatic test_boundary();
        logic [63:0] addrs [5];
        logic [3:0]  exps  [5];
        logic [63:0] lane;
        logic        expErr;
        addrs[0] = 64'h0000_0FFF; exps[0] = 4'b1000;
        addrs[1] = 64'h0000_1000; exps[1] = 4'b0000;
        addrs[2] = 64'h0FFF_FFFF; exps[2] = 4'b0000;
        addrs[3] = 64'h1000_0000; exps[3] = 4'b0001;
        addrs[4] = 64'hFFFF_FFFF; exps[4] = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_i = 2'b01; we_i = 2'b01; addr_i[0] = addrs[i]; wdata_i[0] = 64'h1234_0000 + 64'(i);
            #1;
            checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL bnd%0d_gnt: got %b want 01", i, gnt_o); end
            @(negedge clk);
            req_i = 2'b00;
            #1;
            checks++; if (tgt_req_o !== exps[i]) begin errors++; $display("FAIL bnd%0d_tgt_req: got %b want %b", i, tgt_req_o, exps[i]); end
            if (exps[i] == 4'b0000) begin
                checks++; if (rvalid_o !== 2'b01 || err_o !== 1'b1) begin
                    errors++; $display("FAIL bnd%0d_miss: got rvalid %b err %b want 01 1", i, rvalid_o, err_o);
                end
            end else begin
                checks++; if (tgt_we_o !== 1'b1 || tgt_wdata_o !== 64'h1234_0000 + 64'(i)) begin
                    errors++; $display("FAIL bnd%0d_cmd: got we %b wdata %h", i, tgt_we_o, tgt_wdata_o);
                end
                lane   = 64'hA5A5_0000_0000_0000 + 64'(i);
                expErr = (i == 0);
                for (int k = 0; k < 4; k++) tgt_rdata_i[k] = lane;
                tgt_err_i = expErr ? exps[i] : 4'b0000;
                tgt_gnt_i = exps[i]; tgt_rvalid_i = exps[i];
                @(negedge clk);
                tgt_gnt_i = 4'b0000; tgt_rvalid_i = ~exps[i];
                #1;
                checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL bnd%0d_same_cycle_rvalid: got %b want 00", i, rvalid_o); end
                @(negedge clk);
                tgt_rvalid_i = exps[i];
                #1;
                checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL bnd%0d_foreign_rvalid: got %b want 00", i, rvalid_o); end
                @(negedge clk);
                tgt_rvalid_i = 4'b0000; tgt_err_i = 4'b0000;
                #1;
                checks++; if (rvalid_o !== 2'b01 || rdata_o !== lane || err_o !== expErr) begin
                    errors++; $display("FAIL bnd%0d_rsp: got rvalid %b rdata %h err %b want 01 %h %b", i, rvalid_o, rdata_o, err_o, lane, expErr);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_i = 2'b10; we_i = 2'b00; addr_i[1] = 64'h0200_0010;
        @(negedge clk);
        req_i = 2'b00; tgt_gnt_i = 4'b0100;
        @(negedge clk);
        tgt_gnt_i = 4'b0000; rst_i = 1'b1; tgt_rvalid_i = 4'b0100; tgt_rdata_i[2] = 64'h5555_AAAA;
        @(negedge clk);
        tgt_rvalid_i = 4'b0000;
        #1;
        checks++; if (tgt_req_o !== 4'b0000 || rvalid_o !== 2'b00 || gnt_o !== 2'b00) begin
            errors++; $display("FAIL rstmid_ctrl: got tgt_req %b rvalid %b gnt %b want 0", tgt_req_o, rvalid_o, gnt_o);
        end
        checks++; if (rdata_o !== 64'h0 || err_o !== 1'b0 || tgt_addr_o !== 64'h0) begin
            errors++; $display("FAIL rstmid_regs: got rdata %h err %b addr %h want 0", rdata_o, err_o, tgt_addr_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL rstmid_no_rsp: got %b want 00", rvalid_o); end
    endtask

`ifdef CVA6_WRAPPER_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int hi;
        @(negedge clk);
        req_i = 2'b10; addr_i[1] = 64'h0C00_0010;
        #1;
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL to_gnt: got %b want 10", gnt_o); end
        @(negedge clk);
        req_i = 2'b00;
        #1;
        hi = 0;
        while (tgt_req_o == 4'b0010 && hi < 40) begin
            hi++;
            @(negedge clk);
            #1;
        end
        checks++; if (hi != 16) begin errors++; $display("FAIL to_req_cycles: got %0d want 16", hi); end
        checks++; if (tgt_req_o !== 4'b0000 || rvalid_o !== 2'b10 || err_o !== 1'b1 || rdata_o !== 64'h0) begin
            errors++; $display("FAIL to_rsp: got tgt_req %b rvalid %b err %b rdata %h want 0000 10 1 0", tgt_req_o, rvalid_o, err_o, rdata_o);
        end
        repeat (5) @(negedge clk);
        tgt_rvalid_i = 4'b0010;
        @(negedge clk);
        tgt_rvalid_i = 4'b0000;
        #1;
        checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL to_late1: got %b want 00", rvalid_o); end
        @(negedge clk);
        #1;
        checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL to_late2: got %b want 00", rvalid_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_clint_read();
        test_miss();
        test_boundary();
        test_reset_mid();
`ifdef CVA6_WRAPPER_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cva6_wrapper_bus_arbiter.md
# cva6_wrapper_bus_arbiter

Single-outstanding request/grant bus controller between the wrapper's two initiators (debug module, CVA6 core) and its four SoC targets (External, PLIC, CLINT, Debug). It arbitrates round-robin between initiators and decodes the captured address against the fixed wrapper memory map. It sequences exactly one transaction at a time through a target. Unmapped addresses return an error response and never reach a target.

## Interface
- NumInit, 2: initiators; index 0 = debug, 1 = core
- NumTgt, 4: targets; index 0 = External, 1 = PLIC, 2 = CLINT, 3 = Debug
- AddrWidth, 64: address width
- DataWidth, 64: data width
- TimeoutCycles, 1024: target-abandon limit; used only with the timeout feature
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_i  in  NumInit  initiator request
- we_i  in  NumInit  write enable per initiator
- addr_i  in  NumInit x AddrWidth  address per initiator
- wdata_i  in  NumInit x DataWidth  write data
- be_i  in  NumInit x DataWidth/8  byte enables
- gnt_o  out  NumInit  request accepted; one-cycle pulse
- rvalid_o  out  NumInit  response valid; one-cycle pulse
- rdata_o  out  DataWidth  response data, shared
- err_o  out  1  response error, qualified by rvalid_o
- tgt_req_o  out  NumTgt  one-hot target request
- tgt_we_o / tgt_addr_o / tgt_wdata_o / tgt_be_o  out  1 / AddrWidth / DataWidth / DataWidth/8  shared target command
- tgt_gnt_i  in  NumTgt  target accept
- tgt_rvalid_i  in  NumTgt  target response valid
- tgt_rdata_i  in  NumTgt x DataWidth  target read data
- tgt_err_i  in  NumTgt  target error

## Operation
- Address map, inclusive base, exclusive end (base + length):
  - Debug: 0x0000_0000, length 0x1000
  - CLINT: 0x0200_0000, length 0xC_0000
  - PLIC: 0x0C00_0000, length 0x3FF_FFFF
  - External: 0x1000_0000, length 0xEFFF_FFFF
- The end computation is AddrWidth-bit with no wrap. An address matching no window is a decode miss.
- FSM states: IDLE, REQ, WAIT, RSP.
- IDLE: if any req_i is set, pick the winner, pulse gnt_o[winner], and latch we/addr/wdata/be/owner plus the decoded target into holding registers.
  - Hit: go to REQ.
  - Miss: go to RSP with err=1, rdata=0.
- REQ: tgt_req_o[sel] held high with the command taken from the holding registers. The command is stable until tgt_gnt_i[sel]. On tgt_gnt_i[sel], drop tgt_req_o and go to WAIT.
- WAIT: on tgt_rvalid_i[sel], latch tgt_rdata_i[sel] and tgt_err_i[sel], then go to RSP. Responses from non-selected targets are ignored.
- RSP: pulse rvalid_o[owner] with the latched rdata_o/err_o for one cycle, then return to IDLE.
- Round-robin: the pointer names the preferred initiator. After each grant, the pointer moves to the other initiator. If only one initiator requests, it wins regardless of the pointer.
- Requests that arrive outside IDLE wait. Initiators hold req_i and the command until gnt_o.
- Reset values: state IDLE, pointer = 0, all gnt_o/rvalid_o/tgt_req_o = 0, rdata_o = 0, err_o = 0, holding registers = 0.
- Reset mid-transaction: the transaction is abandoned with no response. tgt_req_o is low from the first cycle after rst_i is sampled.

## Timing
- gnt_o is combinational from req_i in IDLE, in the acceptance cycle N.
- tgt_req_o rises at N+1. With tgt_gnt_i at N+1 and tgt_rvalid_i at N+2, rvalid_o pulses at N+3. The next gnt_o is possible at N+4.
- Decode miss: rvalid_o with err_o=1 at N+1. The next gnt_o is possible at N+2.
- tgt_rvalid_i asserted in the same cycle as tgt_gnt_i is not honoured; it must come from WAIT.
- rdata_o and err_o are registered and hold their values until the next RSP.

## Configuration
- Macro: CVA6_WRAPPER_ARB_TIMEOUT_EN.
- Defined: a counter clears on leaving IDLE and increments each cycle spent in REQ or WAIT. When it reaches TimeoutCycles:
  - tgt_req_o drops;
  - the FSM goes to RSP with err=1, rdata=0;
  - a late tgt_rvalid_i for that transaction is ignored.
- Undefined: no counter; REQ and WAIT wait indefinitely.

## Test plan
- Core read of 0x0200_BFF8, CLINT grants at N+1, rvalid at N+2 with data 0xDEAD_BEEF -> tgt_req_o = 0b0100, rvalid_o[1] at N+3, rdata_o = 0xDEAD_BEEF, err_o = 0.
- Both initiators request continuously from reset -> grants alternate 0, 1, 0, 1. The losing initiator's command is unchanged until its gnt_o.
- Read of 0x0100_0000 (unmapped) -> no tgt_req_o, rvalid_o with err_o = 1 and rdata_o = 0 one cycle after gnt_o.
- Boundary decode: 0x0000_0FFF -> Debug; 0x0000_1000 -> miss; 0x0FFF_FFFF -> miss; 0x1000_0000 -> External; 0xFFFF_FFFF -> miss.
- Timeout enabled, TimeoutCycles = 16, PLIC never grants -> tgt_req_o drops after 16 cycles, rvalid_o with err_o = 1. A PLIC rvalid 5 cycles later produces no response.
- rst_i asserted while in WAIT -> next cycle: state IDLE, all outputs 0. No rvalid_o is produced for the abandoned transaction.
